jk_bank_sequencer: RTL and testbench

- Command-driven controller for a bank of W positive-edge JK flip-flop cells (one cell per bit, same clock).
- Accepts one command at a time over a valid/ready handshake and drives the bank's J/K vectors for a programmed number of cycles: clear, set, load, toggle, count up/down, shift.
- Reads the bank's Q vector back to compute next-state J/K.
- Sits between a host command source and the flip-flop bank; the bank itself has no reset, so this block also performs the power-up clear.

---
 rtl/jk_bank_sequencer.sv | 155 +++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of W JK flip-flops; also performs the bank's power-up clear.
// Optional macro JK_COUNT_SAT_EN: counts saturate at all-ones/zero instead of wrapping and raise sat.
module jk_bank_sequencer #(
    parameter int unsigned W     = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [W-1:0]     q_in,
    output logic [W-1:0]     j_out,
    output logic [W-1:0]     k_out,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_HOLD, OP_CLEAR, OP_SET, OP_LOAD, OP_TOGGLE, OP_UP, OP_DOWN, OP_SHL
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q;
    logic [W-1:0]     data_q;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             accept_c;
    logic [W-1:0]     up_t, dn_t;
    logic [W-1:0]     op_j, op_k;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            rem_q   <= '0;
            op_q    <= OP_HOLD;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (accept_c) begin
                op_q   <= op_t'(cmd_op);
                data_q <= cmd_data;
            end
        end
    end

    // Toggle enables for +1/-1: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin : carry_chain
        logic acc_u;
        logic acc_d;
        acc_u = 1'b1;
        acc_d = 1'b1;
        up_t  = '0;
        dn_t  = '0;
        for (int i = 0; i < int'(W); i++) begin
            up_t[i] = acc_u;
            dn_t[i] = acc_d;
            acc_u   = acc_u & q_in[i];
            acc_d   = acc_d & ~q_in[i];
        end
    end

`ifdef JK_COUNT_SAT_EN
    logic sat_q;
    logic sat_blk_c;

    assign sat_blk_c = ((op_q == OP_UP) && (&q_in)) || ((op_q == OP_DOWN) && ~(|q_in));

    always_ff @(posedge clk) begin
        if (rst || accept_c) begin
            sat_q <= 1'b0;
        end else if ((state_q == S_RUN) && sat_blk_c) begin
            sat_q <= 1'b1;
        end
    end

    assign sat = sat_q & ~rst;
`else
    assign sat = 1'b0;
`endif

    // Per-operation J/K vectors, applied to the bank only while running.
    always_comb begin
        op_j = '0;
        op_k = '0;
        case (op_q)
            OP_HOLD:   ;
            OP_CLEAR:  op_k = '1;
            OP_SET:    op_j = '1;
            OP_LOAD:   begin op_j = data_q; op_k = ~data_q; end
            OP_TOGGLE: begin op_j = data_q; op_k = data_q;  end
            OP_UP:     begin op_j = up_t;   op_k = up_t;    end
            OP_DOWN:   begin op_j = dn_t;   op_k = dn_t;    end
            OP_SHL:    begin op_j = {q_in[W-2:0], data_q[0]}; op_k = ~op_j; end
            default:   ;
        endcase
`ifdef JK_COUNT_SAT_EN
        if (sat_blk_c) begin
            op_j = '0;
            op_k = '0;
        end
`endif
    end

    // Next state and outputs; reset overrides everything so the bank clears from the first edge.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        accept_c  = 1'b0;
        j_out     = '0;
        k_out     = '0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (rst) begin
            k_out = '1;
            busy  = 1'b1;
        end else begin
            case (state_q)
                S_INIT: begin
                    k_out   = '1;
                    busy    = 1'b1;
                    state_d = S_IDLE;
                end
                S_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        accept_c = 1'b1;
                        rem_d    = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    busy  = 1'b1;
                    j_out = op_j;
                    k_out = op_k;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q <= LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural JK flip-flop bank closing the q_in loop.
module tb_jk_bank_sequencer;

    localparam int unsigned W     = 4;
    localparam int unsigned LEN_W = 8;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;
    localparam logic [2:0] OP_SHL    = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [W-1:0]     cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic [W-1:0]     j_out, k_out;
    logic             busy, done, sat;
    logic [W-1:0]     bank_q = 4'b1011;

    int checks = 0;
    int errors = 0;

    jk_bank_sequencer #(.W(W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .q_in      (bank_q),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    // JK bank: J&~K sets, ~J&K clears, J&K toggles, neither holds.
    always @(posedge clk) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge and hold it until accepted; returns at the negedge of the first RUN cycle.
    task automatic send(input logic [2:0] op, input logic [W-1:0] data, input logic [LEN_W-1:0] len);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Expected bank values after each active edge: seq nibble 0 is the first.
    task automatic steps(input string tag, input int len, input logic [39:0] seq);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk({tag, "_q"}, 32'(bank_q), 32'(seq[4*i +: 4]));
            chk({tag, "_done"}, 32'(done), 32'(i == len - 1));
            chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_len   = '0;

        // Power-up clear
        @(negedge clk);
        chk("rst_j", 32'(j_out), 32'h0);
        chk("rst_k", 32'(k_out), 32'hF);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_ready", 32'(cmd_ready), 32'd0);
        chk("init_k", 32'(k_out), 32'hF);
        chk("init_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_q", 32'(bank_q), 32'h0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_jk", 32'({j_out, k_out}), 32'h0);

        // LOAD then HOLD
        send(OP_LOAD, 4'b1010, 8'd1);
        steps("load", 1, 40'hA);
        send(OP_HOLD, 4'b0000, 8'd5);
        chk("hold_busy", 32'(busy), 32'd1);
        steps("hold", 5, 40'hAAAAA);

        // COUNT_UP across the top
        send(OP_LOAD, 4'b1101, 8'd1);
        steps("ld_d", 1, 40'hD);
        send(OP_UP, 4'b0000, 8'd4);
`ifdef JK_COUNT_SAT_EN
        steps("up", 4, 40'hFFFE);
        chk("up_sat", 32'(sat), 32'd1);
`else
        steps("up", 4, 40'h10FE);
        chk("up_sat", 32'(sat), 32'd0);
`endif

        // COUNT_DOWN across the bottom, then TOGGLE
        send(OP_LOAD, 4'b0010, 8'd1);
        steps("ld_2", 1, 40'h2);
        chk("ld_sat_clr", 32'(sat), 32'd0);
        send(OP_DOWN, 4'b0000, 8'd3);
`ifdef JK_COUNT_SAT_EN
        steps("down", 3, 40'h001);
        chk("down_sat", 32'(sat), 32'd1);
        send(OP_TOGGLE, 4'b0101, 8'd2);
        steps("tog", 2, 40'h05);
`else
        steps("down", 3, 40'hF01);
        chk("down_sat", 32'(sat), 32'd0);
        send(OP_TOGGLE, 4'b0101, 8'd2);
        steps("tog", 2, 40'hFA);
`endif
        chk("tog_sat", 32'(sat), 32'd0);

        // SHIFT_L serial-in, then len=0 acting as len=1
        send(OP_LOAD, 4'b0000, 8'd1);
        steps("ld_0", 1, 40'h0);
        send(OP_SHL, 4'b0001, 8'd3);
        steps("shl", 3, 40'h731);
        send(OP_SHL, 4'b0000, 8'd0);
        steps("shl_len0", 1, 40'hE);

        // Back-pressure: a command held during RUN must wait for IDLE
        send(OP_HOLD, 4'b0000, 8'd3);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'b0110;
        cmd_len   = 8'd1;
        steps("bp_hold", 3, 40'hEEE);
        send(OP_LOAD, 4'b0110, 8'd1);
        steps("bp_load", 1, 40'h6);

        // Abort a long COUNT_UP with reset
        send(OP_UP, 4'b0000, 8'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_run_done", 32'(done), 32'd0);
        end
        chk("abort_run_q", 32'(bank_q), 32'h9);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_q", 32'(bank_q), 32'h0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        chk("abort_init_ready", 32'(cmd_ready), 32'd0);
        chk("abort_init_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_idle_ready", 32'(cmd_ready), 32'd1);
        chk("abort_idle_done", 32'(done), 32'd0);
        chk("abort_idle_q", 32'(bank_q), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
